// File: rtl/seq_binary_to_7seg_pkg.sv
// Shared constants, FSM state type and BCD helper for the 7-segment display driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, ABS, SHIFT, ENCODE} state_t;

  // Double-dabble correction applied to a nibble before each left shift.
  function automatic logic [3:0] bcd_add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/seq_binary_to_7seg_if.sv
// Operand handshake and display outputs of the sequential binary-to-7-segment driver.
interface seq_binary_to_7seg_if #(
  parameter int W      = 11,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          in_data;
  logic                  in_tc;
  logic                  out_valid;
  logic [6:0]            seg_sign;
  logic [7*DIGITS-1:0]   seg_digits;
  logic                  too_large;
  logic                  busy;

  modport master (
    output in_valid, in_data, in_tc,
    input  in_ready, out_valid, seg_sign, seg_digits, too_large, busy
  );

  modport slave (
    input  in_valid, in_data, in_tc,
    output in_ready, out_valid, seg_sign, seg_digits, too_large, busy
  );
endinterface

// File: rtl/seq_binary_to_7seg_bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern; blank forces all segments off.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end
endmodule

// File: rtl/seq_binary_to_7seg.sv
// Sequential binary-to-7-segment driver: one double-dabble bit per clock, fixed W+3 cycle turnaround.
// Accepts only when idle; display outputs hold between conversions and update with a one-cycle out_valid.
module seq_binary_to_7seg
  import seg7_pkg::*;
#(
  parameter int W        = 11,
  parameter int DIGITS   = 3,
  parameter int LZ_BLANK = 1
)(
  input  logic               clk,
  input  logic               rst,
  seq_binary_to_7seg_if.slave bus
);
  localparam int MAXV = 10**DIGITS - 1;
  localparam int DW   = $clog2(10**DIGITS);
  localparam int CW   = (W > DW) ? W : DW;
  localparam int CNTW = $clog2(W);
  localparam int BW   = 4*DIGITS;

  state_t                state;
  logic [CNTW-1:0]       cnt;
  logic [W-1:0]          data_r, mag_r;
  logic                  tc_r, neg_r, tl_r;
  logic [BW-1:0]         bcd_r, bcd_adj;
  logic [W-1:0]          mag_abs;
  logic                  neg_abs, tl_abs;
  logic [DIGITS-1:0]     blank_lz;
  logic [7*DIGITS-1:0]   seg_dec;
  logic                  out_valid_r, too_large_r;
  logic [6:0]            seg_sign_r;
  logic [7*DIGITS-1:0]   seg_digits_r;
  logic                  hz;

  always_comb begin
    mag_abs = tc_r ? (data_r[W-1] ? -data_r : data_r) : {1'b0, data_r[W-2:0]};
    // Signed-magnitude negative zero must not light the minus sign.
    neg_abs = data_r[W-1] && (mag_abs != '0);
    tl_abs  = CW'(mag_abs) > CW'(MAXV);
  end

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) bcd_adj[4*i +: 4] = bcd_add3(bcd_r[4*i +: 4]);
  end

  // A digit above the units is blanked when it and all higher digits are zero.
  always_comb begin
    hz       = 1'b1;
    blank_lz = '0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      hz          = hz & (bcd_r[4*i +: 4] == 4'd0);
      blank_lz[i] = (LZ_BLANK != 0) && (i != 0) && hz;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_to_seg7 u_dec (
      .bcd   (bcd_r[4*g +: 4]),
      .blank (blank_lz[g]),
      .seg   (seg_dec[7*g +: 7])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      data_r       <= '0;
      mag_r        <= '0;
      bcd_r        <= '0;
      tc_r         <= 1'b0;
      neg_r        <= 1'b0;
      tl_r         <= 1'b0;
      out_valid_r  <= 1'b0;
      too_large_r  <= 1'b0;
      seg_sign_r   <= SEG_BLANK;
      seg_digits_r <= {DIGITS{SEG_BLANK}};
    end else begin
      out_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_r <= bus.in_data;
            tc_r   <= bus.in_tc;
            state  <= ABS;
          end
        end
        ABS: begin
          mag_r <= mag_abs;
          neg_r <= neg_abs;
          tl_r  <= tl_abs;
          bcd_r <= '0;
          cnt   <= CNTW'(W-1);
          state <= SHIFT;
        end
        SHIFT: begin
          bcd_r <= {bcd_adj[BW-2:0], mag_r[W-1]};
          mag_r <= {mag_r[W-2:0], 1'b0};
          if (cnt == '0) state <= ENCODE;
          else           cnt   <= cnt - 1'b1;
        end
        ENCODE: begin
          seg_sign_r   <= neg_r ? SEG_MINUS : SEG_BLANK;
          seg_digits_r <= tl_r ? {DIGITS{SEG_MINUS}} : seg_dec;
          too_large_r  <= tl_r;
          out_valid_r  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.out_valid  = out_valid_r;
  assign bus.seg_sign   = seg_sign_r;
  assign bus.seg_digits = seg_digits_r;
  assign bus.too_large  = too_large_r;
endmodule

// File: tb/tb_seq_binary_to_7seg.sv
// Directed self-checking bench for seq_binary_to_7seg with three parameterisations.
module tb_seq_binary_to_7seg;
  localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001, D2 = 7'b0100100, D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001, D5 = 7'b0010010, D6 = 7'b0000010, D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000, D9 = 7'b0010000, DB = 7'b1111111, DM = 7'b0111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   pulses0 = 0;
  int   m;
  int   p;

  always #5 clk = ~clk;

  seq_binary_to_7seg_if #(.W(11), .DIGITS(3)) b0 ();
  seq_binary_to_7seg_if #(.W(11), .DIGITS(3)) b1 ();
  seq_binary_to_7seg_if #(.W(16), .DIGITS(5)) b2 ();

  seq_binary_to_7seg #(.W(11), .DIGITS(3), .LZ_BLANK(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  seq_binary_to_7seg #(.W(11), .DIGITS(3), .LZ_BLANK(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  seq_binary_to_7seg #(.W(16), .DIGITS(5), .LZ_BLANK(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

  always @(negedge clk) if (b0.out_valid === 1'b1) pulses0++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait0(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); cyc++; @(negedge clk);
    end while (b0.out_valid !== 1'b1 && cyc < 40);
  endtask

  task automatic wait1(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); cyc++; @(negedge clk);
    end while (b1.out_valid !== 1'b1 && cyc < 40);
  endtask

  task automatic wait2(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); cyc++; @(negedge clk);
    end while (b2.out_valid !== 1'b1 && cyc < 40);
  endtask

  // Offer one operand to u0, scramble in_data after the accepting edge, wait for the result.
  task automatic conv0(input logic [10:0] d, input logic tc, output int cyc);
    @(negedge clk);
    b0.in_valid = 1'b1; b0.in_data = d; b0.in_tc = tc;
    @(posedge clk);
    @(negedge clk);
    b0.in_valid = 1'b0; b0.in_data = 11'h555; b0.in_tc = ~tc;
    wait0(cyc);
  endtask

  initial begin
    b0.in_valid = 1'b0; b0.in_data = '0; b0.in_tc = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_tc = 1'b1;
    b2.in_valid = 1'b0; b2.in_data = '0; b2.in_tc = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",   64'(b0.in_ready), 64'd1);
    check("rst_busy",       64'(b0.busy), 64'd0);
    check("rst_out_valid",  64'(b0.out_valid), 64'd0);
    check("rst_too_large",  64'(b0.too_large), 64'd0);
    check("rst_seg_sign",   64'(b0.seg_sign), 64'(DB));
    check("rst_seg_digits", 64'(b0.seg_digits), 64'({DB, DB, DB}));
    rst = 1'b0;

    conv0(11'd725, 1'b1, m);
    check("tc725_latency", 64'(m), 64'd13);
    check("tc725_in_ready", 64'(b0.in_ready), 64'd1);
    check("tc725_sign", 64'(b0.seg_sign), 64'(DB));
    check("tc725_digits", 64'(b0.seg_digits), 64'({D7, D2, D5}));
    check("tc725_too_large", 64'(b0.too_large), 64'd0);
    @(negedge clk);
    check("tc725_pulse_one_cycle", 64'(b0.out_valid), 64'd0);
    check("tc725_hold_digits", 64'(b0.seg_digits), 64'({D7, D2, D5}));

    conv0(11'h7FD, 1'b1, m);
    check("tcm3_sign", 64'(b0.seg_sign), 64'(DM));
    check("tcm3_digits", 64'(b0.seg_digits), 64'({DB, DB, D3}));

    conv0(11'b10000000011, 1'b0, m);
    check("smm3_sign", 64'(b0.seg_sign), 64'(DM));
    check("smm3_digits", 64'(b0.seg_digits), 64'({DB, DB, D3}));

    conv0(11'b10000000000, 1'b0, m);
    check("smnegzero_sign", 64'(b0.seg_sign), 64'(DB));
    check("smnegzero_digits", 64'(b0.seg_digits), 64'({DB, DB, D0}));

    conv0(11'd1000, 1'b1, m);
    check("tc1000_too_large", 64'(b0.too_large), 64'd1);
    check("tc1000_sign", 64'(b0.seg_sign), 64'(DB));
    check("tc1000_digits", 64'(b0.seg_digits), 64'({DM, DM, DM}));

    // -1024 then 999 with in_valid held high across the out_valid cycle
    @(negedge clk);
    b0.in_valid = 1'b1; b0.in_data = 11'h400; b0.in_tc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.in_data = 11'd999;
    wait0(m);
    check("tcm1024_latency", 64'(m), 64'd13);
    check("tcm1024_too_large", 64'(b0.too_large), 64'd1);
    check("tcm1024_sign", 64'(b0.seg_sign), 64'(DM));
    check("tcm1024_digits", 64'(b0.seg_digits), 64'({DM, DM, DM}));
    @(posedge clk);
    @(negedge clk);
    b0.in_valid = 1'b0;
    wait0(m);
    check("b2b999_latency", 64'(m), 64'd13);
    check("b2b999_too_large", 64'(b0.too_large), 64'd0);
    check("b2b999_sign", 64'(b0.seg_sign), 64'(DB));
    check("b2b999_digits", 64'(b0.seg_digits), 64'({D9, D9, D9}));

    // in_valid held with changing data while busy: only 123 is converted
    #1 p = pulses0;
    @(negedge clk);
    b0.in_valid = 1'b1; b0.in_data = 11'd123; b0.in_tc = 1'b1;
    m = 0;
    do begin
      @(posedge clk); m++; @(negedge clk);
      if (b0.out_valid !== 1'b1) b0.in_data = 11'($urandom_range(0, 2047));
    end while (b0.out_valid !== 1'b1 && m < 40);
    b0.in_valid = 1'b0;
    check("held_latency", 64'(m), 64'd14);
    check("held_digits", 64'(b0.seg_digits), 64'({D1, D2, D3}));
    repeat (20) @(negedge clk);
    #1;
    check("held_pulse_count", 64'(pulses0 - p), 64'd1);

    // LZ_BLANK=0 instance
    @(negedge clk);
    b1.in_valid = 1'b1; b1.in_data = 11'd5; b1.in_tc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.in_valid = 1'b0;
    wait1(m);
    check("nolz5_latency", 64'(m), 64'd13);
    check("nolz5_sign", 64'(b1.seg_sign), 64'(DB));
    check("nolz5_digits", 64'(b1.seg_digits), 64'({D0, D0, D5}));

    // W=16, DIGITS=5 instance
    @(negedge clk);
    b2.in_valid = 1'b1; b2.in_data = 16'h8000; b2.in_tc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b2.in_valid = 1'b0;
    wait2(m);
    check("w16_latency", 64'(m), 64'd18);
    check("w16_sign", 64'(b2.seg_sign), 64'(DM));
    check("w16_too_large", 64'(b2.too_large), 64'd0);
    check("w16_digits", 64'(b2.seg_digits), 64'({D3, D2, D7, D6, D8}));

    // Reset five cycles into a conversion
    @(negedge clk);
    b0.in_valid = 1'b1; b0.in_data = 11'd456; b0.in_tc = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b0.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_sign", 64'(b0.seg_sign), 64'(DB));
    check("midrst_digits", 64'(b0.seg_digits), 64'({DB, DB, DB}));
    check("midrst_in_ready", 64'(b0.in_ready), 64'd1);
    check("midrst_out_valid", 64'(b0.out_valid), 64'd0);
    p = pulses0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("midrst_no_pulse", 64'(pulses0 - p), 64'd0);
    check("midrst_in_ready_after", 64'(b0.in_ready), 64'd1);

    conv0(11'd42, 1'b1, m);
    check("postrst_latency", 64'(m), 64'd13);
    check("postrst_digits", 64'(b0.seg_digits), 64'({DB, D4, D2}));
    check("postrst_sign", 64'(b0.seg_sign), 64'(DB));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
